gte_microcode_sequencer: RTL and testbench
==========================================

// Module: gte_microcode_sequencer
// PURPOSE
// Sequences the GTE microcode ROM for one GTE command at a time.
// - Maps the 6-bit command opcode to a start PC and steps the PC each cycle.
// - Compensates for the ROM's 1-cycle registered read.
// - Ends the run on the ROM's last-entry flag; supplies the new-instruction and FAST/SLOW select to ROM and datapath.
// - Sits between the CPU COP2 command interface and the microcode ROM / compute datapath.
// PARAMETERS
// PC_W        9    width of microcode PC
// ROM_LAST    321  highest valid ROM address; watchdog limit
// START_FILE  "MicroCodeStart.inl"  64-entry start-PC table (opcode->PC); entry value 0 = invalid opcode
// PORTS
// i_clk        in   1     clock
// i_rst        in   1     async reset, active high
// i_run        in   1     start pulse; sampled only when o_busy=0
// i_instr      in   6     command opcode, sampled with i_run
// i_useFast    in   1     FAST/SLOW mode, sampled with i_run
// i_stall      in   1     freeze sequencing (host register access / divider wait)
// i_lastInstr  in   1     ROM last-entry flag (already FAST/SLOW-qualified), entry of PC presented 1 cycle earlier
// o_PC         out  PC_W  ROM address (registered)
// o_romRdEn    out  1     ROM read clock-enable (=!i_stall while running)
// o_isNewInstr out  1     1-cycle pulse: first ROM entry of a command is visible
// o_useFast    out  1     latched mode, stable for whole run
// o_busy       out  1     command in progress
// o_done       out  1     1-cycle completion pulse
// o_invalid    out  1     sticky: last command had invalid opcode; cleared on next accepted i_run
// o_error      out  1     sticky: watchdog abort; cleared on next accepted i_run
// BEHAVIOUR
// Reset: state IDLE; o_PC=0; o_busy=0; o_done=0; o_isNewInstr=0; o_useFast=0; o_invalid=0; o_error=0; o_romRdEn=1.
// States: IDLE -> FETCH -> EXEC -> IDLE. DONE is a 1-cycle pulse, not a state.
// IDLE:
//  - i_run=1 with valid opcode: o_PC<=start[i_instr]; latch o_useFast; o_busy<=1; next FETCH.
//  - i_run=1 with table entry 0: o_invalid<=1; o_done<=1 for 1 cycle; no PC change; remain IDLE.
// FETCH (ROM entry for start PC not yet valid):
//  - o_PC<=o_PC+1; next EXEC; o_isNewInstr<=1 so it is high while entry[start] is presented.
// EXEC (i_lastInstr describes entry o_PC-1):
//  - i_lastInstr=1: o_PC<=0; o_busy<=0; o_done<=1; next IDLE.
//  - else o_PC<=o_PC+1.
// Watchdog: in EXEC with o_PC==ROM_LAST and i_lastInstr=0, abort: o_error<=1, o_done<=1, o_busy<=0, o_PC<=0, IDLE. o_PC never wraps past ROM_LAST.
// Stall: while i_stall=1 in FETCH/EXEC, the following hold:
//  - o_PC and state; o_romRdEn=0 (ROM output held); o_isNewInstr held.
//  - Stall outranks i_lastInstr: completion evaluates only on the first unstalled cycle.
// i_stall in IDLE is ignored.
// i_run while o_busy=1 is ignored (no queue); CPU interlock guarantees ordering.
// Async reset mid-run: immediate return to reset values; no o_done pulse.
// Latency: accepted i_run -> o_done = entry count + 2 cycles (no stall).
// TESTING
// 1) Test ROM: opcode 0x06 start=10, last flag at PC17; i_run edge E0.
//    Required: o_PC=10 after E0, ..., 17 after E7; o_isNewInstr high after E1 only; o_done high after E9 for 1 cycle; o_busy high E0..E9.
// 2) Same as 1 with i_stall high 3 cycles after E4: o_PC frozen at 14; o_romRdEn=0; o_done delayed exactly 3 cycles.
// 3) i_instr=0x00 (table 0): o_done pulse next cycle, o_invalid=1, o_busy never set; next valid run clears o_invalid.
// 4) i_run with i_useFast=1, toggle i_useFast low mid-run: o_useFast stays 1 until o_done; i_run during busy ignored.
// 5) Test ROM without last flag from start 300: o_PC reaches 321, o_error=1, o_done pulse, o_PC=0, never 322.
// 6) Assert i_rst at E5 of scenario 1: all outputs at reset values immediately; no o_done; fresh i_run restarts at PC 10.

Source files
------------

// File: rtl/gte_microcode_sequencer.sv
// GTE microcode sequencer: maps a COP2 opcode to a start PC and steps the ROM address,
// absorbing the ROM's one-cycle registered read. START_TABLE packs opcode n at [n*PC_W +: PC_W].
module gte_microcode_sequencer #(
  parameter int                 PC_W        = 9,
  parameter int                 ROM_LAST    = 321,
  parameter logic [64*PC_W-1:0] START_TABLE = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_run,
  input  logic [5:0]      i_instr,
  input  logic            i_useFast,
  input  logic            i_stall,
  input  logic            i_lastInstr,
  output logic [PC_W-1:0] o_PC,
  output logic            o_romRdEn,
  output logic            o_isNewInstr,
  output logic            o_useFast,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_invalid,
  output logic            o_error
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            new_q, new_d;
  logic            fast_q, fast_d;
  logic            done_q, done_d;
  logic            invalid_q, invalid_d;
  logic            error_q, error_d;
  logic [PC_W-1:0] start_pc;

  assign start_pc = START_TABLE[i_instr*PC_W +: PC_W];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      new_q     <= 1'b0;
      fast_q    <= 1'b0;
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      new_q     <= new_d;
      fast_q    <= fast_d;
      done_q    <= done_d;
      invalid_q <= invalid_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    new_d     = new_q;
    fast_d    = fast_q;
    done_d    = 1'b0;
    invalid_d = invalid_q;
    error_d   = error_q;
    unique case (state_q)
      IDLE: begin
        new_d = 1'b0;
        if (i_run) begin
          invalid_d = 1'b0;
          error_d   = 1'b0;
          if (start_pc == '0) begin
            invalid_d = 1'b1;
            done_d    = 1'b1;
          end else begin
            pc_d    = start_pc;
            fast_d  = i_useFast;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (!i_stall) begin
          pc_d    = pc_q + PC_W'(1);
          new_d   = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // i_lastInstr refers to entry pc_q-1; a stalled cycle never evaluates it
        if (!i_stall) begin
          new_d = 1'b0;
          if (i_lastInstr) begin
            pc_d    = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (pc_q == PC_W'(ROM_LAST)) begin
            pc_d    = '0;
            done_d  = 1'b1;
            error_d = 1'b1;
            state_d = IDLE;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy       = (state_q != IDLE);
  assign o_romRdEn    = ~(o_busy & i_stall);
  assign o_PC         = pc_q;
  assign o_isNewInstr = new_q;
  assign o_useFast    = fast_q;
  assign o_done       = done_q;
  assign o_invalid    = invalid_q;
  assign o_error      = error_q;

endmodule

// File: tb/tb_gte_microcode_sequencer.sv
// Self-checking bench: bench-side registered ROM of last flags plus a run-level model
// predicting PC / pulses from the count of unstalled cycles since acceptance.
module tb_gte_microcode_sequencer;

  localparam int PC_W     = 9;
  localparam int ROM_LAST = 321;

  function automatic logic [PC_W-1:0] start_of(input int op);
    if (op == 6)      return PC_W'(10);
    if (op == 63)     return PC_W'(300);
    if (op % 5 == 0)  return '0;
    return PC_W'(op * 4 + 20);
  endfunction

  function automatic logic [64*PC_W-1:0] mk_table();
    logic [64*PC_W-1:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r[i*PC_W +: PC_W] = start_of(i);
    return r;
  endfunction

  localparam logic [64*PC_W-1:0] TBL = mk_table();

  logic            i_clk, i_rst, i_run, i_useFast, i_stall, i_lastInstr;
  logic [5:0]      i_instr;
  logic [PC_W-1:0] o_PC;
  logic            o_romRdEn, o_isNewInstr, o_useFast, o_busy, o_done, o_invalid, o_error;

  gte_microcode_sequencer #(.PC_W(PC_W), .ROM_LAST(ROM_LAST), .START_TABLE(TBL)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_run(i_run), .i_instr(i_instr),
    .i_useFast(i_useFast), .i_stall(i_stall), .i_lastInstr(i_lastInstr),
    .o_PC(o_PC), .o_romRdEn(o_romRdEn), .o_isNewInstr(o_isNewInstr),
    .o_useFast(o_useFast), .o_busy(o_busy), .o_done(o_done),
    .o_invalid(o_invalid), .o_error(o_error)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic flag [0:511];
  logic rom_q;
  always @(posedge i_clk or posedge i_rst)
    if (i_rst) rom_q <= 1'b0;
    else if (o_romRdEn) rom_q <= flag[o_PC];
  assign i_lastInstr = rom_q;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_flags(input int s, input int n);
    for (int i = 0; i < 512; i++) flag[i] = 1'b0;
    if (n > 0) flag[s+n-1] = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, o_PC, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_new"}, o_isNewInstr, 0);
    chk({tag, "_fast"}, o_useFast, 0);
    chk({tag, "_inv"}, o_invalid, 0);
    chk({tag, "_err"}, o_error, 0);
    chk({tag, "_rden"}, o_romRdEn, 1);
  endtask

  // n = entry count (last flag at start+n-1); n = 0 means no last flag -> watchdog
  task automatic run_cmd(input int op, input int n, input bit fast, input bit rnd,
                         input int st_k, input int st_len);
    int s, k, endk, stl, guard;
    bit st, err_exp;
    s = int'(start_of(op));
    set_flags(s, n);
    i_instr = 6'(op); i_useFast = fast; i_run = 1'b1;
    i_stall = 1'($urandom_range(0, 1));
    step();
    i_run = 1'b0;
    if (s == 0) begin
      chk("inv_done", o_done, 1);
      chk("inv_flag", o_invalid, 1);
      chk("inv_busy", o_busy, 0);
      chk("inv_pc", o_PC, 0);
      step();
      chk("inv_done_pulse", o_done, 0);
      chk("inv_busy2", o_busy, 0);
      return;
    end
    chk("acc_pc", o_PC, s);
    chk("acc_busy", o_busy, 1);
    chk("acc_inv_clr", o_invalid, 0);
    chk("acc_err_clr", o_error, 0);
    chk("acc_fast", o_useFast, fast);
    endk    = (n > 0) ? n + 1 : ROM_LAST + 1 - s;
    err_exp = (n == 0);
    k = 0; stl = 0; guard = 0;
    while (1) begin
      if (st_len > 0 && k == st_k && stl < st_len) begin st = 1'b1; stl++; end
      else st = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      i_stall   = st;
      i_run     = 1'($urandom_range(0, 1));
      i_instr   = 6'($urandom_range(0, 63));
      i_useFast = 1'($urandom_range(0, 1));
      #1;
      chk("rden", o_romRdEn, !st);
      step();
      if (!st) k++;
      guard++;
      if (guard > 2000) begin
        chk("run_timeout", guard, 0);
        break;
      end
      if (k == endk) begin
        chk("end_done", o_done, 1);
        chk("end_busy", o_busy, 0);
        chk("end_pc", o_PC, 0);
        chk("end_err", o_error, err_exp);
        chk("end_fast", o_useFast, fast);
        break;
      end
      chk("run_pc", o_PC, s + k);
      chk("run_busy", o_busy, 1);
      chk("run_done", o_done, 0);
      chk("run_new", o_isNewInstr, k == 1);
      chk("run_fast", o_useFast, fast);
    end
    i_run = 1'b0; i_stall = 1'b0;
    step();
    chk("done_pulse", o_done, 0);
    chk("idle_new", o_isNewInstr, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int op;
    i_rst = 1'b1; i_run = 1'b0; i_instr = '0; i_useFast = 1'b0; i_stall = 1'b0;
    set_flags(0, 0);
    #12;
    chk_reset_vals("reset");
    i_rst = 1'b0;
    step();

    // basic run: opcode 6, entries 10..17
    run_cmd(6, 8, 1'b0, 1'b0, 0, 0);
    // 3-cycle stall once PC reaches 14
    run_cmd(6, 8, 1'b0, 1'b0, 4, 3);
    // invalid opcode, then a valid run clears the sticky flag
    run_cmd(0, 0, 1'b0, 1'b0, 0, 0);
    chk("inv_sticky", o_invalid, 1);
    run_cmd(6, 8, 1'b1, 1'b0, 0, 0);
    chk("inv_cleared", o_invalid, 0);
    // stall during FETCH, single-entry command
    run_cmd(7, 1, 1'b1, 1'b0, 0, 2);
    // watchdog from 300
    run_cmd(63, 0, 1'b0, 1'b0, 0, 0);
    chk("wd_sticky", o_error, 1);

    // reset mid-run at E5
    set_flags(10, 8);
    i_instr = 6'd6; i_useFast = 1'b1; i_run = 1'b1;
    step();
    i_run = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_pc", o_PC, 15);
    i_rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    step();
    chk("midrst_done", o_done, 0);
    i_rst = 1'b0;
    step();
    chk("postrst_done", o_done, 0);
    run_cmd(6, 8, 1'b0, 1'b0, 0, 0);

    // randomized commands with random stalls
    for (int r = 0; r < 24; r++) begin
      op = $urandom_range(1, 62);
      run_cmd(op, $urandom_range(1, 12), 1'($urandom_range(0, 1)), 1'b1, 0, 0);
      for (int w = $urandom_range(0, 2); w > 0; w--) begin
        i_stall = 1'($urandom_range(0, 1));
        step();
        chk("idle_busy", o_busy, 0);
        chk("idle_rden", o_romRdEn, 1);
      end
      i_stall = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
